// File: rtl/alu_share_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module  : alu_share_arbiter                                                 |
// | Brief   : Round-robin sharing of one combinational ALU between two          |
// |           requesters, with a single registered result slot.                 |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_op,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic            grant_vld;
  logic            grant_idx;
  logic            can_accept;
  logic            handshake;

  // On contention the requester that did not win last time gets the ALU.
  always_comb begin
    grant_vld  = |req_valid;
    grant_idx  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    can_accept = (state_q == EMPTY) || ((state_q == FULL) && rsp_ready[owner_q]);
    req_ready  = 2'b00;
    if (grant_vld && can_accept && !reset) begin
      req_ready[grant_idx] = 1'b1;
    end
    handshake  = |(req_valid & req_ready);
  end

  always_comb begin
    alu_ctrl = 4'b0000;
    alu_a    = '0;
    alu_b    = '0;
    if (grant_vld) begin
      if (grant_idx) begin
        alu_ctrl = req_op[7:4];
        alu_a    = req_a[2*XLEN-1:XLEN];
        alu_b    = req_b[2*XLEN-1:XLEN];
      end else begin
        alu_ctrl = req_op[3:0];
        alu_a    = req_a[XLEN-1:0];
        alu_b    = req_b[XLEN-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    zero_d       = zero_q;
    if (handshake) begin
      state_d      = FULL;
      owner_d      = grant_idx;
      last_grant_d = grant_idx;
      result_d     = alu_result;
      zero_d       = alu_zero;
    end else if ((state_q == FULL) && rsp_ready[owner_q]) begin
      state_d      = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign rsp_valid  = (state_q == FULL) ? (2'b01 << owner_q) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module  : tb_alu_share_arbiter                                              |
// | Brief   : Directed bench with a transaction-level model of the shared slot. |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_share_arbiter;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [7:0]        req_op = '0;
  logic [2*XLEN-1:0] req_a = '0;
  logic [2*XLEN-1:0] req_b = '0;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   alu_a, alu_b, alu_result;
  logic              alu_zero;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = '0;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 10 SRA.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the slot as a single-entry response record plus the round-robin turn.
  bit          m_full = 1'b0;
  bit          m_owner = 1'b0;
  logic [31:0] m_res = '0;
  bit          m_zero = 1'b0;
  bit          m_last = 1'b1;
  logic [1:0]  m_rdy;
  bit          m_g;

  function automatic logic [3:0]  op_of(input bit i); return i ? req_op[7:4] : req_op[3:0]; endfunction
  function automatic logic [31:0] a_of(input bit i);  return i ? req_a[63:32] : req_a[31:0]; endfunction
  function automatic logic [31:0] b_of(input bit i);  return i ? req_b[63:32] : req_b[31:0]; endfunction

  function automatic bit who_wins();
    if (req_valid == 2'b11) return !m_last;
    return req_valid[1];
  endfunction

  function automatic logic [1:0] exp_ready();
    bit room;
    room = !m_full || rsp_ready[m_owner];
    if (reset || req_valid == 2'b00 || !room) return 2'b00;
    return who_wins() ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_full = 1'b0; m_owner = 1'b0; m_res = '0; m_zero = 1'b0; m_last = 1'b1;
    end else begin
      m_rdy = exp_ready();
      if (m_rdy != 2'b00) begin
        m_g     = m_rdy[1];
        m_res   = alu_fn(op_of(m_g), a_of(m_g), b_of(m_g));
        m_zero  = (m_res == 0);
        m_owner = m_g;
        m_last  = m_g;
        m_full  = 1'b1;
      end else if (m_full && rsp_ready[m_owner]) begin
        m_full = 1'b0;
      end
    end
  end

  bit hs_log[$];
  bit log_en = 1'b0;

  always @(negedge clk) begin
    bit g;
    g = who_wins();
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready()});
    chk("alu_ctrl", {28'd0, alu_ctrl}, (req_valid != 0) ? {28'd0, op_of(g)} : 32'd0);
    chk("alu_a", alu_a, (req_valid != 0) ? a_of(g) : 32'd0);
    chk("alu_b", alu_b, (req_valid != 0) ? b_of(g) : 32'd0);
    chk("rsp_valid", {30'd0, rsp_valid}, m_full ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
    if (log_en && !reset && (req_valid & req_ready) != 2'b00) hs_log.push_back(req_ready[1]);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (i) begin req_op[7:4] = op; req_a[63:32] = a; req_b[63:32] = b; end
    else   begin req_op[3:0] = op; req_a[31:0]  = a; req_b[31:0]  = b; end
  endtask

  initial begin
    // Reset state, with a request pending to show ready is gated by reset
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    set_req(0, 4'b0000, 32'd5, 32'd7);
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single ADD 5+7
    @(negedge clk); chk("t1_ready", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_zero", {31'd0, rsp_zero}, 32'd0);
    tick();

    // 2: both valid right after reset, req 0 goes first
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(0, 4'b0001, 32'd10, 32'd3);
    set_req(1, 4'b0100, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    @(negedge clk); chk("t2_ready0", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b10;
    @(negedge clk);
    chk("t2_ready1", {30'd0, req_ready}, 32'd2);
    chk("t2_res0", rsp_result, 32'd7);
    chk("t2_valid0", {30'd0, rsp_valid}, 32'd1);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    chk("t2_res1", rsp_result, 32'hFF);
    chk("t2_valid1", {30'd0, rsp_valid}, 32'd2);
    tick();

    // 3: backpressure holds a zero result while req 1 waits
    set_req(0, 4'b0001, 32'd5, 32'd5);
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk); chk("t3_ready0", {30'd0, req_ready}, 32'd1);
    tick();
    set_req(1, 4'b0000, 32'd1, 32'd2);
    req_valid = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_valid", {30'd0, rsp_valid}, 32'd1);
      chk("t3_hold_result", rsp_result, 32'd0);
      chk("t3_hold_zero", {31'd0, rsp_zero}, 32'd1);
      chk("t3_hold_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 2'b01;
    @(negedge clk); chk("t3_refill_ready", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    chk("t3_res1", rsp_result, 32'd3);
    chk("t3_valid1", {30'd0, rsp_valid}, 32'd2);
    tick();

    // 4: continuous contention, eight back-to-back ops
    hs_log.delete();
    log_en = 1'b1;
    set_req(0, 4'b0000, 32'd100, 32'd200);
    set_req(1, 4'b0001, 32'd50, 32'd8);
    req_valid = 2'b11;
    repeat (8) begin @(negedge clk); tick(); end
    req_valid = 2'b00;
    log_en = 1'b0;
    chk("t4_hs_count", hs_log.size(), 32'd8);
    for (int i = 0; i < hs_log.size(); i++) chk("t4_grant_seq", {31'd0, hs_log[i]}, i % 2);
    @(negedge clk);
    chk("t4_last_res", rsp_result, 32'd42);
    chk("t4_last_owner", {30'd0, rsp_valid}, 32'd2);
    tick();

    // 5: async reset while req 1 owns the slot
    set_req(1, 4'b0000, 32'd1, 32'd1);
    req_valid = 2'b10; rsp_ready = 2'b00;
    @(negedge clk); chk("t5_ready1", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    @(negedge clk); chk("t5_full_owner1", {30'd0, rsp_valid}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", {30'd0, rsp_valid}, 32'd0);
    chk("t5_async_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 4'b0010, 32'hFF00, 32'h0FF0);
    set_req(1, 4'b0011, 32'h1, 32'h2);
    req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk); chk("t5_first_grant", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b10;
    @(negedge clk); chk("t5_and_res", rsp_result, 32'h0F00);
    tick(); req_valid = 2'b00;
    tick();

    // 6: SRA for req 1, only the other requester's ready is high
    set_req(1, 4'b1010, 32'h8000_0000, 32'd4);
    req_valid = 2'b10; rsp_ready = 2'b01;
    @(negedge clk); chk("t6_ready1", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_valid", {30'd0, rsp_valid}, 32'd2);
      chk("t6_hold_result", rsp_result, 32'hF800_0000);
      tick();
    end
    rsp_ready = 2'b10;
    @(negedge clk); chk("t6_before_drain", {30'd0, rsp_valid}, 32'd2);
    tick();
    @(negedge clk); chk("t6_drained", {30'd0, rsp_valid}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
